// File: rtl/mem_responder.sv
// Multi-cycle memory responder: accepts one request at a time and answers
// single reads/writes and critical-word-first 4-word line reads after LAT cycles.
module mem_responder #(
  parameter int LAT    = 4,
  parameter int ADDR_W = 16,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_burst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  output logic [15:0]       rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);
  localparam logic [1:0] LAST_BURST_BEAT = 2'(BURST - 1);
  localparam int WORDS = 1 << (ADDR_W - 1);

  logic [1:0]        state_reg;
  logic [3:0]        lat_cnt_reg;
  logic [1:0]        beat_cnt_reg;
  logic              wr_reg;
  logic              burst_reg;
  logic [ADDR_W-2:0] word_reg;
  logic [15:0]       wdata_reg;
  logic [ADDR_W-1:0] rsp_addr_reg;
  logic [15:0]       rsp_data_reg;
  logic [15:0]       mem [WORDS];

  logic              last_beat;
  logic [1:0]        next_idx;
  logic [ADDR_W-1:0] next_addr;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = req_addr[0];

  assign last_beat = (beat_cnt_reg == (burst_reg ? LAST_BURST_BEAT : 2'd0));
  // Line reads wrap inside the 8-byte line; the carry never reaches bit 3.
  assign next_idx  = rsp_addr_reg[2:1] + 2'd1;
  assign next_addr = {rsp_addr_reg[ADDR_W-1:3], next_idx, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      lat_cnt_reg  <= 4'd0;
      beat_cnt_reg <= 2'd0;
      wr_reg       <= 1'b0;
      burst_reg    <= 1'b0;
      word_reg     <= '0;
      wdata_reg    <= 16'd0;
      rsp_addr_reg <= '0;
      rsp_data_reg <= 16'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            wr_reg      <= req_wr;
            burst_reg   <= req_burst & ~req_wr;
            word_reg    <= req_addr[ADDR_W-1:1];
            wdata_reg   <= req_wdata;
            lat_cnt_reg <= LAT_M1;
            state_reg   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt_reg == 4'd0) begin
            state_reg    <= S_SEND;
            beat_cnt_reg <= 2'd0;
            rsp_addr_reg <= {word_reg, 1'b0};
            rsp_data_reg <= wr_reg ? wdata_reg : mem[word_reg];
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 4'd1;
          end
        end
        S_SEND: begin
          if (last_beat) begin
            state_reg <= S_IDLE;
          end else begin
            beat_cnt_reg <= beat_cnt_reg + 2'd1;
            rsp_addr_reg <= next_addr;
            rsp_data_reg <= mem[next_addr[ADDR_W-1:1]];
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Commit happens only at the edge ending a write beat, so a reset earlier aborts it.
  always_ff @(posedge clk) begin
    if (state_reg == S_SEND && wr_reg) begin
      mem[word_reg] <= wdata_reg;
    end
  end

  assign req_ready = (state_reg == S_IDLE);
  assign busy      = ~req_ready;
  assign rsp_valid = (state_reg == S_SEND);
  assign rsp_last  = (state_reg == S_SEND) && last_beat;
  assign rsp_data  = rsp_data_reg;
  assign rsp_addr  = rsp_addr_reg;

endmodule
